// File: rtl/alu_share_arb_pkg.sv
// Shared constants and state encoding for the two-port ALU sharing arbiter.
package alu_share_arb_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned OPW_DEF   = 2;

   localparam logic [1:0] OP_ADDU = 2'b00;
   localparam logic [1:0] OP_SUBU = 2'b01;
   localparam logic [1:0] OP_OR   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_share_arb_rr_pick2.sv
// Two-input round-robin picker: on a tie the requester that did not win last time is chosen.
module rr_pick2
   import alu_share_arb_pkg::*;
(
   input  logic v0,
   input  logic v1,
   input  logic last,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = v0 | v1;
      gnt_id    = 1'b0;
      if (v0 && v1) begin
         gnt_id = ~last;
      end else if (v1) begin
         gnt_id = 1'b1;
      end
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters with round-robin arbitration.
// Define ALU_ARB_OVERLAP_EN to accept the next request in the cycle a response is taken.
module alu_share_arb
   import alu_share_arb_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned OPW   = OPW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_ctr,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero
);

   state_t           state;
   logic             last_grant;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [OPW-1:0]   op_ctr;
   logic             op_id;
   logic [WIDTH-1:0] res;
   logic             zero;

   logic             gnt_valid;
   logic             gnt_id;
   logic             arb_open;
   logic             accept;

   rr_pick2 u_pick (
      .v0        (req0_valid),
      .v1        (req1_valid),
      .last      (last_grant),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

`ifdef ALU_ARB_OVERLAP_EN
   assign arb_open = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);
`else
   assign arb_open = (state == S_IDLE);
`endif

   assign req0_ready = arb_open && gnt_valid && !gnt_id;
   assign req1_ready = arb_open && gnt_valid && gnt_id;
   // A grant always implies the granted valid, so either ready is a handshake.
   assign accept     = req0_ready || req1_ready;

   assign alu_a      = op_a;
   assign alu_b      = op_b;
   assign alu_ctr    = op_ctr;
   assign rsp_id     = op_id;
   assign rsp_result = res;
   assign rsp_zero   = zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         op_a       <= '0;
         op_b       <= '0;
         op_ctr     <= '0;
         op_id      <= 1'b0;
         res        <= '0;
         zero       <= 1'b0;
         rsp_valid  <= 1'b0;
      end else begin
         if (accept) begin
            op_a       <= gnt_id ? req1_a : req0_a;
            op_b       <= gnt_id ? req1_b : req0_b;
            op_ctr     <= gnt_id ? req1_op : req0_op;
            op_id      <= gnt_id;
            last_grant <= gnt_id;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               res       <= alu_out;
               zero      <= alu_zero;
               rsp_valid <= 1'b1;
               state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= accept ? S_EXEC : S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: behavioural transaction model plus directed literals.
module tb_alu_share_arb;
   import alu_share_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [1:0]  req0_op = '0, req1_op = '0;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [1:0]  alu_ctr;
   logic        alu_zero;
   logic        rsp_valid, rsp_id, rsp_zero;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;

   alu_share_arb dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ctr    (alu_ctr),
      .alu_out    (alu_out),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
      case (op)
         OP_SUBU: ref_alu = a - b;
         OP_OR:   ref_alu = a | b;
         default: ref_alu = a + b;
      endcase
   endfunction

   // External ALU the arbiter is wired to.
   assign alu_out  = ref_alu(alu_a, alu_b, alu_ctr);
   assign alu_zero = (alu_a == alu_b);

`ifdef ALU_ARB_OVERLAP_EN
   localparam int PERIOD = 2;
`else
   localparam int PERIOD = 3;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Requester drivers: hold a request until the model reports it accepted.
   bit          pend[2];
   bit          took[2];
   logic [31:0] pa[2], pb[2];
   logic [1:0]  pop[2];
   int          gen_rate[2];
   bit          rsp_rand = 1'b0;

   task automatic apply();
      req0_valid = pend[0];
      req0_a     = pa[0];
      req0_b     = pb[0];
      req0_op    = pop[0];
      req1_valid = pend[1];
      req1_a     = pa[1];
      req1_b     = pb[1];
      req1_op    = pop[1];
   endtask

   task automatic drive_cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (took[i]) begin
            took[i] = 1'b0;
            pend[i] = 1'b0;
         end
         if (!pend[i] && ($urandom_range(0, 99) < gen_rate[i])) begin
            pa[i]   = $urandom;
            pb[i]   = ($urandom_range(0, 3) == 0) ? pa[i] : $urandom;
            pop[i]  = 2'($urandom_range(0, 3));
            pend[i] = 1'b1;
         end
      end
      if (rsp_rand) rsp_ready = ($urandom_range(0, 99) < 70);
      apply();
   endtask

   // Behavioural model: one transaction in flight, response visible two cycles after accept.
   bit          mon_en = 1'b0;
   bit          m_have = 1'b0;
   int          m_age = 0;
   bit          m_last = 1'b1;
   logic [31:0] m_la = '0, m_lb = '0, m_res = '0;
   logic [1:0]  m_lop = '0;
   bit          m_zero = 1'b0, m_id = 1'b0;
   int          wait_n[2];

   bit          e_open, e_wv, e_w, e_rv, e_r0, e_r1, prev_rv = 1'b0;
   int          dut_acc_cyc = 0, last_lat = 0, rsp_cnt = 0;
   logic [31:0] last_res = '0;
   bit          last_zero = 1'b0, last_id = 1'b0;
   int          gseq[$];
   int          acc_cycs[$];

   initial forever begin
      @(negedge clk);
      cyc++;
      e_wv = req0_valid | req1_valid;
      e_w  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      e_rv = m_have && (m_age >= 2);
`ifdef ALU_ARB_OVERLAP_EN
      e_open = !m_have || (e_rv && rsp_ready);
`else
      e_open = !m_have;
`endif
      e_r0 = e_open && e_wv && !e_w;
      e_r1 = e_open && e_wv && e_w;
      if (mon_en) begin
         chk("req0_ready", 32'(req0_ready), 32'(e_r0));
         chk("req1_ready", 32'(req1_ready), 32'(e_r1));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         if (e_rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
         end
         chk("alu_a", alu_a, m_la);
         chk("alu_b", alu_b, m_lb);
         chk("alu_ctr", 32'(alu_ctr), 32'(m_lop));
         if (rsp_valid && !prev_rv) last_lat = cyc - dut_acc_cyc;
         prev_rv = rsp_valid;
         if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) begin
            dut_acc_cyc = cyc;
            gseq.push_back((req1_ready && req1_valid) ? 1 : 0);
            acc_cycs.push_back(cyc);
         end
         if (rsp_valid && rsp_ready && !reset) begin
            rsp_cnt++;
            last_res  = rsp_result;
            last_zero = rsp_zero;
            last_id   = rsp_id;
         end
      end
      if (reset) begin
         m_have = 1'b0; m_age = 0; m_last = 1'b1;
         m_la = '0; m_lb = '0; m_lop = '0; m_res = '0; m_zero = 1'b0; m_id = 1'b0;
         wait_n[0] = 0; wait_n[1] = 0;
      end else begin
         if (m_have && m_age == 1) m_age = 2;
         if (e_rv && rsp_ready) m_have = 1'b0;
         if (e_r0 || e_r1) begin
            m_have = 1'b1;
            m_age  = 1;
            m_last = e_w;
            m_id   = e_w;
            m_la   = e_w ? req1_a : req0_a;
            m_lb   = e_w ? req1_b : req0_b;
            m_lop  = e_w ? req1_op : req0_op;
            m_res  = ref_alu(m_la, m_lb, m_lop);
            m_zero = (m_la == m_lb);
            took[e_w] = 1'b1;
            if (mon_en) chk("no_starve", 32'(wait_n[e_w] <= 2), 32'd1);
            wait_n[e_w] = 0;
            if (e_w ? req0_valid : req1_valid) wait_n[~e_w]++;
         end
      end
   end

   task automatic one_op(input string nm, input bit id, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] op,
                         input logic [31:0] er, input bit ez);
      int start;
      start   = rsp_cnt;
      pa[id]  = a;
      pb[id]  = b;
      pop[id] = op;
      pend[id] = 1'b1;
      apply();
      for (int k = 0; k < 20 && rsp_cnt == start; k++) drive_cycle();
      chk({nm, "_done"}, 32'(rsp_cnt != start), 32'd1);
      chk({nm, "_result"}, last_res, er);
      chk({nm, "_zero"}, 32'(last_zero), 32'(ez));
      chk({nm, "_id"}, 32'(last_id), 32'(id));
      chk({nm, "_latency"}, last_lat, 32'd2);
   endtask

   initial begin
      int start;
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      gen_rate = '{0, 0};
      pend     = '{0, 0};
      pa = '{0, 0}; pb = '{0, 0}; pop = '{0, 0};
      apply();
      repeat (3) drive_cycle();
      reset  = 1'b0;
      mon_en = 1'b1;
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_alu_a", alu_a, 32'd0);
      chk("reset_alu_b", alu_b, 32'd0);
      chk("reset_alu_ctr", 32'(alu_ctr), 32'd0);
      chk("reset_ready0", 32'(req0_ready), 32'd0);
      chk("reset_ready1", 32'(req1_ready), 32'd0);

      rsp_ready = 1'b1;
      one_op("addu_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, OP_ADDU, 32'h8000_0000, 1'b0);
      one_op("subu_wrap", 1'b1, 32'd5, 32'd7, OP_SUBU, 32'hFFFF_FFFE, 1'b0);
      one_op("or", 1'b1, 32'hF0F0_0000, 32'h0000_F0F0, OP_OR, 32'hF0F0_F0F0, 1'b0);
      one_op("subu_eq", 1'b0, 32'h1234, 32'h1234, OP_SUBU, 32'd0, 1'b1);
      one_op("op3_add", 1'b0, 32'd2, 32'd3, 2'b11, 32'd5, 1'b0);

      // Round robin from reset with both requesters always valid.
      reset = 1'b1;
      pend  = '{0, 0};
      apply();
      repeat (2) drive_cycle();
      reset = 1'b0;
      gseq.delete();
      acc_cycs.delete();
      gen_rate = '{100, 100};
      repeat (14) drive_cycle();
      gen_rate = '{0, 0};
      chk("rr_count", 32'(gseq.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < gseq.size(); i++) chk("rr_grant", gseq[i], i % 2);
      for (int i = 0; i < 3 && i + 1 < acc_cycs.size(); i++)
         chk("rr_gap", acc_cycs[i+1] - acc_cycs[i], PERIOD);
      repeat (15) drive_cycle();

      // Response backpressure with a competing request pending.
      start     = rsp_cnt;
      rsp_ready = 1'b0;
      pa[0] = 32'd9; pb[0] = 32'd4; pop[0] = OP_SUBU; pend[0] = 1'b1;
      apply();
      for (int k = 0; k < 10 && !rsp_valid; k++) drive_cycle();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      pa[1] = 32'd3; pb[1] = 32'd4; pop[1] = OP_OR; pend[1] = 1'b1;
      apply();
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp_hold_result", rsp_result, 32'd5);
         chk("bp_hold_id", 32'(rsp_id), 32'd0);
         chk("bp_ready0", 32'(req0_ready), 32'd0);
         chk("bp_ready1", 32'(req1_ready), 32'd0);
         drive_cycle();
         #1;
      end
      rsp_ready = 1'b1;
      #1;
`ifdef ALU_ARB_OVERLAP_EN
      chk("bp_next_accept", 32'(req1_ready), 32'd1);
`else
      chk("bp_no_accept_in_resp", 32'(req1_ready), 32'd0);
      drive_cycle();
      #1;
      chk("bp_next_accept", 32'(req1_ready), 32'd1);
`endif
      for (int k = 0; k < 20 && rsp_cnt < start + 2; k++) drive_cycle();
      chk("bp_second_result", last_res, 32'd7);
      chk("bp_second_id", 32'(last_id), 32'd1);
      repeat (3) drive_cycle();

      // Reset while the ALU cycle is in progress.
      start = rsp_cnt;
      pa[0] = 32'hDEAD_0000; pb[0] = 32'd1; pop[0] = OP_ADDU; pend[0] = 1'b1;
      apply();
      #1;
      chk("rst_accept", 32'(req0_ready), 32'd1);
      drive_cycle();
      reset = 1'b1;
      drive_cycle();
      reset = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      for (int k = 0; k < 10; k++) begin
         drive_cycle();
         #1;
         chk("rst_no_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      chk("rst_no_response", rsp_cnt, start);
      pa[1] = 32'd1; pb[1] = 32'd1; pop[1] = OP_ADDU; pend[1] = 1'b1;
      apply();
      #1;
      chk("rst_idle_ready", 32'(req1_ready), 32'd1);
      repeat (6) drive_cycle();

      // Randomized traffic and backpressure.
      rsp_rand = 1'b1;
      for (int chunk = 0; chunk < 10; chunk++) begin
         gen_rate[0] = $urandom_range(0, 100);
         gen_rate[1] = $urandom_range(0, 100);
         repeat (200) drive_cycle();
      end
      gen_rate  = '{0, 0};
      rsp_rand  = 1'b0;
      rsp_ready = 1'b1;
      repeat (20) drive_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational ALU (32-bit A/B, 2-bit ALUctr, Output, zero) between two requesters, e.g. a main datapath port and a branch-compare/debug port.
- Arbitration is round-robin. Operands are latched, the ALU result is registered, and the result is returned on a valid/ready response channel tagged with the requester ID.
- Sits between the requesters and the single ALU instance; owns the ALU's A, B and ALUctr inputs.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath.
- OPW, 2, op-code width; must match ALUctr.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an op pending.
- req0_ready  output  1  requester 0 op accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_op  input  OPW  requester 0 op: 00 addu, 01 subu, 10 or, 11 treated as addu.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_ctr  output  OPW  to ALU ALUctr.
- alu_out  input  WIDTH  ALU Output.
- alu_zero  input  1  ALU zero (A==B).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_id  output  1  requester ID that owns the result.
- rsp_result  output  WIDTH  registered ALU Output.
- rsp_zero  output  1  registered ALU zero.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset value is IDLE.
- Reset values: last_grant=1 (so req0 wins the first tie); op_a/op_b/op_ctr/res/zero/id regs=0; rsp_valid=0; both ready=0.
- Arbitration (IDLE only, combinational):
  - only one valid: grant that requester.
  - both valid: grant the requester != last_grant.
  - neither valid: no grant.
- reqN_ready = (state==IDLE) && grant==N. At most one ready is high per cycle. Ready never depends on ready.
- Accept on valid&&ready: latch a, b, op, id; set last_grant=id; move to EXEC.
- EXEC (one cycle): alu_a/alu_b/alu_ctr come from the latched regs. At the edge, capture res=alu_out and zero=alu_zero, then move to RESP.
- alu_a/alu_b/alu_ctr always reflect the latched regs, in every state. They are 0 after reset.
- RESP:
  - rsp_valid=1; rsp_result, rsp_zero and rsp_id are stable until the handshake.
  - on rsp_ready=1: go to IDLE.
  - on rsp_ready=0: stay; backpressure is unbounded.
- Latency: accept at edge t; EXEC during cycle t+1; rsp_valid high from cycle t+2. Throughput is 1 op per 3 cycles with rsp_ready tied high.
- Arithmetic: modulo 2^WIDTH with no overflow flag; subu wraps. Op 11 returns A+B.
- Requests that arrive while busy see ready=0 and must hold valid and operands stable.
- The request that loses a tie stays pending and is guaranteed the next grant. No starvation: a waiting requester is served within 2 transactions.
- Reset mid-operation: the in-flight transaction is discarded, no response is issued, and all state returns to reset values on the next edge.

Optional Feature:
- Macro: ALU_ARB_OVERLAP_EN.
- Defined:
  - in RESP, when rsp_ready=1, the arbiter also evaluates grants with IDLE rules.
  - a request accepted in that same cycle goes directly to EXEC.
  - throughput is 1 op per 2 cycles.
  - last_grant updates identically to a normal accept.
- Undefined: behaviour is exactly as above; ready is only ever asserted in IDLE.

Decomposition:
- Shared package/header holds:
  - op-code localparams OP_ADDU=2'b00, OP_SUBU=2'b01, OP_OR=2'b10;
  - state encodings S_IDLE=2'd0, S_EXEC=2'd1, S_RESP=2'd2;
  - WIDTH default.
- One natural sub-module: rr_pick2. It is a 2-input round-robin picker with inputs v0, v1, last and outputs gnt_valid, gnt_id. It is purely combinational.
- The ALU itself stays outside, instantiated alongside and wired by the integrator.

Test Plan:
- Single req0 addu, a=0x7FFFFFFF, b=1 -> req0_ready at cycle t; rsp_valid at t+2; rsp_result=0x80000000, rsp_zero=0, rsp_id=0.
- req1 subu, a=5, b=7 -> rsp_result=0xFFFFFFFE, rsp_id=1. Then or with a=0xF0F00000, b=0x0000F0F0 -> rsp_result=0xF0F0F0F0.
- Both valid continuously with rsp_ready=1 -> grant sequence 0,1,0,1. Each rsp_id matches. No requester waits more than 2 transactions.
- Response backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and the result are held constant; both ready outputs stay 0; the next accept occurs the cycle after rsp_ready=1 (IDLE).
- Equal operands subu, a=b=0x1234 -> rsp_result=0, rsp_zero=1. Op 11 with a=2, b=3 -> rsp_result=5.
- Reset asserted during EXEC -> next cycle: state IDLE, rsp_valid=0, alu_a=alu_b=0, and no response is ever produced. With ALU_ARB_OVERLAP_EN, back-to-back requests give rsp_valid every 2nd cycle.
